mac_window_accumulator: RTL

Downstream consumer of the multiply-accumulate register stage. It takes the stage's registered result stream (`DATA_OUT`, qualified by a system-supplied valid strobe) and sums fixed-length windows of `WINDOW` consecutive valid samples. Each completed window sum is presented on a valid/ready output port backed by a two-entry result queue. The upstream stage is free-running and cannot be stalled, so queue overflow is flagged, not back-pressured.

---
 rtl/mac_window_accumulator_pkg.sv | 23 ++
 rtl/mac_window_accumulator_result_skid_buffer.sv | 96 +++++++++
 rtl/mac_window_accumulator.sv | 83 ++++++++
 3 files changed

// File: rtl/mac_window_accumulator_pkg.sv
// Shared parameters and types for the MAC datapath and its window accumulator.
//   DATA_WIDTH     : operand width feeding the multiply-accumulate stage
//   DATA_OUT_WIDTH : registered result width of the MAC stage
//   WINDOW_LEN     : default number of samples summed per window
//   ACC_WIDTH      : window sum width, sized so a full window cannot overflow
//   acc_t          : window sum type
//   q_state_t      : occupancy of the two-entry result queue
package params;

    localparam int DATA_WIDTH     = 8;
    localparam int DATA_OUT_WIDTH = 16;
    localparam int WINDOW_LEN     = 8;
    localparam int ACC_WIDTH      = DATA_OUT_WIDTH + $clog2(WINDOW_LEN);

    typedef logic [ACC_WIDTH-1:0] acc_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } q_state_t;

endpackage

// File: rtl/mac_window_accumulator_result_skid_buffer.sv
// result_skid_buffer: two-entry queue holding completed window sums.
// The producer cannot be stalled, so a push into a full queue without a
// simultaneous pop drops the new sum and sets a sticky overrun flag.
//   clk, reset  : clock, asynchronous active-high reset
//   push        : a window sum is offered this cycle
//   push_data   : the offered window sum
//   out_ready   : consumer accepts the head this cycle
//   out_valid   : head entry is valid (registered)
//   out_sum     : head entry (registered, stable while stalled)
//   overrun     : sticky, a sum was dropped
module result_skid_buffer
    import params::*;
#(
    parameter int ACC_WIDTH = params::ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [ACC_WIDTH-1:0] push_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 overrun
);

    q_state_t               state, state_n;
    logic [ACC_WIDTH-1:0]   head, head_n;
    logic [ACC_WIDTH-1:0]   pend, pend_n;
    logic                   ovr, ovr_n;
    logic                   valid_r;
    logic                   pop;

    assign pop = valid_r & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EMPTY;
            head    <= '0;
            pend    <= '0;
            ovr     <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state   <= state_n;
            head    <= head_n;
            pend    <= pend_n;
            ovr     <= ovr_n;
            // Separate flop so out_valid never passes through decode logic.
            valid_r <= (state_n != EMPTY);
        end
    end

    always_comb begin
        state_n = state;
        head_n  = head;
        pend_n  = pend;
        ovr_n   = ovr;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_n = ONE;
                    head_n  = push_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_n = push_data;
                end else if (push) begin
                    state_n = TWO;
                    pend_n  = push_data;
                end else if (pop) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (push && pop) begin
                    head_n = pend;
                    pend_n = push_data;
                end else if (pop) begin
                    state_n = ONE;
                    head_n  = pend;
                end else if (push) begin
                    // Full and not draining: the new sum is lost.
                    ovr_n = 1'b1;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

    assign out_valid = valid_r;
    assign out_sum   = head;
    assign overrun   = ovr;

endmodule

// File: rtl/mac_window_accumulator.sv
// mac_window_accumulator: sums fixed windows of WINDOW consecutive valid
// samples from the MAC stage and presents each sum on a valid/ready port
// backed by a two-entry queue.
//   clk, reset : clock, asynchronous active-high reset
//   in_valid   : in_data carries a sample this cycle
//   in_data    : unsigned sample from the MAC stage
//   clear      : synchronous window restart (discards that cycle's sample)
//   out_ready  : consumer accepts out_sum this cycle
//   out_valid  : out_sum holds a completed window sum
//   out_sum    : unsigned window sum
//   overrun    : sticky, a window sum was dropped
module mac_window_accumulator
    import params::*;
#(
    parameter int WINDOW    = params::WINDOW_LEN,
    parameter int ACC_WIDTH = params::ACC_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_OUT_WIDTH-1:0]  in_data,
    input  logic                       clear,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [ACC_WIDTH-1:0]       out_sum,
    output logic                       overrun
);

    localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    // Unsigned widening add; ACC_WIDTH covers a full window so no wrap occurs.
    function automatic logic [ACC_WIDTH-1:0] add_sample(
        input logic [ACC_WIDTH-1:0]      a,
        input logic [DATA_OUT_WIDTH-1:0] d
    );
        return a + ACC_WIDTH'(d);
    endfunction

    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic [ACC_WIDTH-1:0] sum_next;
    logic                 accept;
    logic                 last;
    logic                 push;

    assign accept   = in_valid & ~clear;
    assign last     = (cnt == CNT_LAST);
    assign push     = accept & last;
    assign sum_next = add_sample(acc, in_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum_next;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    result_skid_buffer #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (sum_next),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .overrun   (overrun)
    );

endmodule
